// File: rtl/sc_fifo_pkg.sv
// Shared definitions for the sc_fifo write-side arbiters.
//   - FSM state encoding for the packet-aware write arbiter
//   - rr_next(): round-robin pointer advance, modulo the requester count
//   - idw_fits(): source-ID width check used at elaboration
package sc_fifo_pkg;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam int MIN_NREQ = 2;
  localparam int MAX_NREQ = 16;

  // Wraps at nreq-1, not at 2**IDW, so non-power-of-two requester counts
  // never point at a requester that does not exist.
  function automatic int rr_next(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

  function automatic bit idw_fits(input int nreq, input int idw);
    return (1 << idw) >= nreq;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of valid_i, scanning from
// ptr_i upward and wrapping at NREQ-1 back to 0.
// Ports:
//   valid_i  [NREQ]  request vector
//   ptr_i    [IDW]   scan start (must be < NREQ)
//   found_o          at least one request set
//   idx_o    [IDW]   index of the picked request (0 when none)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);

  // Offsets are visited from farthest to nearest so the nearest valid
  // requester is the last assignment and therefore the winner.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (valid_i[k] && (k == ((int'(ptr_i) + off) % NREQ))) begin
          found_o = 1'b1;
          idx_o   = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/sc_fifo_wr_arb.sv
// Packet-aware round-robin write arbiter sharing one sc_fifo write port
// between NREQ producers. Each FIFO word is {source id, payload}.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ARB   | no packet in flight; pick next requester round-robin
//   LOCK  | multi-beat packet in flight; only grant_id may transfer
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid/last/data   per-requester beat, requester k at [k*DW +: DW]
//   req_ready             per-requester accept (combinational)
//   fifo_datain/wr_op     FIFO write port (combinational)
//   fifo_full/afull       FIFO backpressure flags
//   fifo_wr_full_err      FIFO sticky overflow flag
//   fifo_clr_err          one-cycle clear pulse to the FIFO
//   sw_clr_err            software error clear
//   arb_err               sticky: overflow or protocol violation seen
//   grant_id, pkt_active  current/last grant, high while locked
//
// A reset mid-packet abandons the lock; the partial packet already written
// stays in the FIFO and the consumer must cope with it.
module sc_fifo_wr_arb
  import sc_fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 2,
  parameter int PTRW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_last,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [DW+IDW-1:0]   fifo_datain,
  output logic                fifo_wr_op,
  input  logic                fifo_full,
  input  logic                fifo_afull,
  input  logic                fifo_wr_full_err,
  output logic                fifo_clr_err,
  input  logic                sw_clr_err,
  output logic                arb_err,
  output logic [IDW-1:0]      grant_id,
  output logic                pkt_active
);

  if (!idw_fits(NREQ, IDW)) begin : g_bad_idw
    $error("sc_fifo_wr_arb: 2**IDW must be >= NREQ");
  end
  if (NREQ < MIN_NREQ || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("sc_fifo_wr_arb: NREQ out of range");
  end
  if (PTRW < 1) begin : g_bad_ptrw
    $error("sc_fifo_wr_arb: PTRW must be positive");
  end

  logic [0:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            arb_err_q, arb_err_d;
  logic            clr_err_q;

  logic            cand_found;
  logic [IDW-1:0]  cand_idx;

  logic [NREQ-1:0] gnt_mask, cand_mask;
  logic            gnt_valid, gnt_last, cand_last;
  logic [DW-1:0]   gnt_data, cand_data;
  logic            proto_viol;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (cand_found),
    .idx_o   (cand_idx)
  );

  // Mux the granted and candidate requesters without variable indexing.
  always_comb begin
    gnt_mask  = '0;
    cand_mask = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    cand_last = 1'b0;
    cand_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == grant_id_q) begin
        gnt_mask[k] = 1'b1;
        gnt_valid   = req_valid[k];
        gnt_last    = req_last[k];
        gnt_data    = req_data[k*DW +: DW];
      end
      if (IDW'(k) == cand_idx) begin
        cand_mask[k] = 1'b1;
        cand_last    = req_last[k];
        cand_data    = req_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    req_ready   = '0;
    fifo_wr_op  = 1'b0;
    fifo_datain = {grant_id_q, gnt_data};
    proto_viol  = 1'b0;

    case (state_q)
      ST_ARB: begin
        // afull gates new packets only; full is also checked so a write is
        // never issued into a full FIFO even if afull is mis-sequenced.
        if (cand_found && !fifo_afull && !fifo_full) begin
          req_ready   = cand_mask;
          fifo_wr_op  = 1'b1;
          fifo_datain = {cand_idx, cand_data};
          grant_id_d  = cand_idx;
          if (cand_last) begin
            rr_ptr_d = IDW'(rr_next(int'(cand_idx), NREQ));
          end else begin
            state_d = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        req_ready  = gnt_mask & {NREQ{~fifo_full}};
        fifo_wr_op = gnt_valid & ~fifo_full;
        if (fifo_wr_op && gnt_last) begin
          state_d  = ST_ARB;
          rr_ptr_d = IDW'(rr_next(int'(grant_id_q), NREQ));
        end
        // Another requester ending a packet while the owner is idle means a
        // producer ignored ready; flagged only, arbitration is unaffected.
        proto_viol = ~gnt_valid & (|(req_valid & req_last & ~gnt_mask));
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Set has priority over the software clear.
  always_comb begin
    arb_err_d = arb_err_q;
    if (fifo_wr_full_err || proto_viol) begin
      arb_err_d = 1'b1;
    end else if (sw_clr_err) begin
      arb_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      arb_err_q  <= 1'b0;
      clr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      arb_err_q  <= arb_err_d;
      clr_err_q  <= sw_clr_err;
    end
  end

  assign grant_id     = grant_id_q;
  assign pkt_active   = (state_q == ST_LOCK);
  assign arb_err      = arb_err_q;
  assign fifo_clr_err = clr_err_q;

endmodule

// File: tb/tb_sc_fifo_wr_arb.sv
module tb_sc_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int PTRW = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [DW+IDW-1:0]   fifo_datain;
  logic                fifo_wr_op;
  logic                fifo_full;
  logic                fifo_afull;
  logic                fifo_wr_full_err;
  logic                fifo_clr_err;
  logic                sw_clr_err;
  logic                arb_err;
  logic [IDW-1:0]      grant_id;
  logic                pkt_active;

  sc_fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .PTRW(PTRW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_datain      (fifo_datain),
    .fifo_wr_op       (fifo_wr_op),
    .fifo_full        (fifo_full),
    .fifo_afull       (fifo_afull),
    .fifo_wr_full_err (fifo_wr_full_err),
    .fifo_clr_err     (fifo_clr_err),
    .sw_clr_err       (sw_clr_err),
    .arb_err          (arb_err),
    .grant_id         (grant_id),
    .pkt_active       (pkt_active)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: lock flag, owner and round-robin pointer as plain ints.
  bit m_lock;
  int m_gid, m_ptr;
  bit m_err, m_clr;

  bit              chk_en = 0;
  logic [NREQ-1:0] e_ready;
  bit              e_wr;
  int              e_gid;
  bit              e_pkt, e_err, e_clr;
  logic [DW+IDW-1:0] exp_q[$];
  int              wr_ids[$];

  task automatic eval();
    bit viol;
    int cand;
    if (!reset_n) begin
      m_lock = 0; m_gid = 0; m_ptr = 0; m_err = 0; m_clr = 0;
    end
    e_gid = m_gid; e_pkt = m_lock; e_err = m_err; e_clr = m_clr;
    e_ready = '0; e_wr = 0; viol = 0;
    if (!m_lock) begin
      cand = -1;
      for (int off = 0; off < NREQ; off++) begin
        int k = (m_ptr + off) % NREQ;
        if (cand < 0 && req_valid[k]) cand = k;
      end
      if (cand >= 0 && !fifo_afull && !fifo_full) begin
        e_ready[cand] = 1'b1;
        e_wr = 1;
        exp_q.push_back({IDW'(cand), req_data[cand*DW +: DW]});
        if (reset_n) begin
          m_gid = cand;
          if (req_last[cand]) m_ptr = (cand + 1) % NREQ;
          else m_lock = 1;
        end
      end
    end else begin
      e_ready[m_gid] = !fifo_full;
      if (req_valid[m_gid] && !fifo_full) begin
        e_wr = 1;
        exp_q.push_back({IDW'(m_gid), req_data[m_gid*DW +: DW]});
        if (req_last[m_gid]) begin
          m_lock = 0;
          m_ptr = (m_gid + 1) % NREQ;
        end
      end
      if (!req_valid[m_gid])
        for (int k = 0; k < NREQ; k++)
          if (k != m_gid && req_valid[k] && req_last[k]) viol = 1;
    end
    if (reset_n) begin
      if (fifo_wr_full_err || viol) m_err = 1;
      else if (sw_clr_err) m_err = 0;
      m_clr = sw_clr_err;
    end
    chk_en = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("wr_op", fifo_wr_op, e_wr);
      if (fifo_wr_op) begin
        wr_ids.push_back(int'(fifo_datain[DW +: IDW]));
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else check("fifo_datain", fifo_datain, exp_q.pop_front());
      end else if (e_wr && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      check("grant_id", grant_id, e_gid);
      check("pkt_active", pkt_active, e_pkt);
      check("arb_err", arb_err, e_err);
      check("fifo_clr_err", fifo_clr_err, e_clr);
    end
  end

  task automatic step();
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0;
    fifo_full = 0; fifo_afull = 0; fifo_wr_full_err = 0; sw_clr_err = 0;
  endtask

  task automatic set_req(input int k, input bit v, input bit l);
    req_valid[k] = v;
    req_last[k]  = l;
    req_data[k*DW +: DW] = $urandom;
  endtask

  task automatic check_ids(input string name, input int exp[]);
    check({name, "_count"}, wr_ids.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_ids.size(); i++)
      check(name, wr_ids[i], exp[i]);
  endtask

  initial begin
    reset_n = 0;
    req_data = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    step();                       // reset values checked while reset held
    reset_n = 1;

    // 1: req0 and req2 single-beat packets continuously
    wr_ids.delete();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 1); set_req(2, 1, 1);
      step();
    end
    idle_inputs(); step();
    check_ids("t1_grants", '{0, 2, 0, 2, 0, 2});

    // 2: req1 3-beat packet while req3 valid; a req0 beat first moves rr_ptr to 1
    set_req(0, 1, 1); step(); idle_inputs();
    wr_ids.delete();
    for (int b = 0; b < 4; b++) begin
      set_req(1, b < 3, b == 2); set_req(3, 1, 1);
      step();
    end
    idle_inputs(); step();
    check_ids("t2_grants", '{1, 1, 1, 3});

    // 3: afull in ARB, afull in LOCK, full in LOCK
    fifo_afull = 1; set_req(0, 1, 0); step(); step();
    fifo_afull = 0; set_req(0, 1, 0); step();        // packet starts, lock
    fifo_afull = 1; set_req(0, 1, 0); step(); step();
    fifo_full = 1; set_req(0, 1, 0); step(); step(); step();
    fifo_full = 0; set_req(0, 1, 1); step();
    idle_inputs(); step();

    // 4: locked requester drops valid for 5 cycles while others are valid
    set_req(2, 1, 0); step();
    wr_ids.delete();
    for (int i = 0; i < 5; i++) begin
      set_req(2, 0, 0); set_req(0, 1, 0); set_req(3, 1, 0);
      step();
    end
    check("t4_no_writes", wr_ids.size(), 0);
    check("t4_lock_held", pkt_active, 1);
    idle_inputs(); set_req(2, 1, 1); step();
    idle_inputs(); step();
    check_ids("t4_resume", '{2});

    // 5: error set, clear, simultaneous set and clear
    fifo_wr_full_err = 1; step();
    fifo_wr_full_err = 0; step();
    sw_clr_err = 1; step();
    sw_clr_err = 0; step(); step();
    fifo_wr_full_err = 1; step();
    sw_clr_err = 1; step();
    fifo_wr_full_err = 0; sw_clr_err = 0; step(); step();

    // 6: reset during beat 2 of a 4-beat packet from req2
    set_req(2, 1, 0); step();
    reset_n = 0; set_req(2, 1, 0); step(); step();
    reset_n = 1;
    wr_ids.delete();
    set_req(1, 1, 1); set_req(2, 1, 1); step();
    idle_inputs(); step();
    check_ids("t6_first", '{1});

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NREQ; k++)
        set_req(k, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      fifo_afull = $urandom_range(0, 9) < 2;
      fifo_full = fifo_afull && $urandom_range(0, 1);
      fifo_wr_full_err = $urandom_range(0, 49) == 0;
      sw_clr_err = $urandom_range(0, 29) == 0;
      step();
    end
    idle_inputs(); step();
    chk_en = 0;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
